// File: rtl/game_pkg.sv
// Shared constants and types for the player physics scheduler.
//   - screen / sprite geometry and the motion tuning values
//   - key and collision-hit bit indices
//   - scheduler FSM state enum
package game_pkg;

    localparam int X_MAX    = 640;   // screen width, pixels
    localparam int Y_MAX    = 480;   // screen height, pixels
    localparam int SPR_W    = 32;    // sprite width
    localparam int SPR_H    = 32;    // sprite height
    localparam int H_STEP   = 2;     // horizontal pixels per frame
    localparam int JUMP_V   = 14;    // jump launch speed (upward)
    localparam int GRAV     = 1;     // per-frame vy increment
    localparam int MAX_FALL = 14;    // downward vy ceiling
    localparam int ACK_TMO  = 255;   // collision ack timeout, cycles

    localparam int RED_X0  = 32;
    localparam int RED_Y0  = 416;
    localparam int BLUE_X0 = 96;
    localparam int BLUE_Y0 = 416;

    localparam int KEY_JUMP  = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_RIGHT = 3;

    localparam int HIT_V = 0;
    localparam int HIT_H = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROP   = 3'd1,
        ST_QUERY  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/player_physics_sched_if.sv
// Collision-checker query channel.
//   col_req/col_id/col_x/col_y : query from the scheduler (master)
//   col_ack/col_hit            : response from the checker (slave)
// Handshake: col_req is a valid that stays high, with col_id/col_x/col_y
// held stable, until the first cycle col_ack is sampled high; col_ack is
// the checker's one-cycle response strobe and col_hit is only meaningful
// in that cycle. col_req drops on the cycle after the ack.
interface player_physics_sched_if;
    logic       col_req;
    logic       col_id;
    logic [9:0] col_x;
    logic [8:0] col_y;
    logic       col_ack;
    logic [1:0] col_hit;

    modport master (output col_req, col_id, col_x, col_y,
                    input  col_ack, col_hit);
    modport slave  (input  col_req, col_id, col_x, col_y,
                    output col_ack, col_hit);
endinterface

// File: rtl/player_kinematics.sv
// Combinational propose step for one player.
//   in : key_jump/key_left/key_right, x, y, vy (signed), grounded
//   out: px (clamped to screen), py (clamped), vy_p (velocity used this frame)
module player_kinematics
    import game_pkg::*;
(
    input  logic              key_jump,
    input  logic              key_left,
    input  logic              key_right,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic signed [5:0] vy,
    input  logic              grounded,
    output logic [9:0]        px,
    output logic [8:0]        py,
    output logic signed [5:0] vy_p
);
    localparam logic [10:0]        PX_MAX  = 11'(X_MAX - SPR_W);
    localparam logic [10:0]        STEP    = 11'(H_STEP);
    localparam logic signed [10:0] PY_MAX  = 11'(Y_MAX - SPR_H);
    localparam logic signed [5:0]  VY_JUMP = 6'(-JUMP_V);

    logic [10:0]        x_ext;
    logic [10:0]        x_right;
    logic signed [10:0] y_sum;

    always_comb begin
        x_ext   = {1'b0, x};
        x_right = x_ext + STEP;
        px      = x;
        // Opposing keys cancel out.
        if (key_left && !key_right)
            px = (x_ext >= STEP) ? 10'(x_ext - STEP) : 10'd0;
        else if (key_right && !key_left)
            px = (x_right > PX_MAX) ? PX_MAX[9:0] : x_right[9:0];

        vy_p = (key_jump && grounded) ? VY_JUMP : vy;

        // 11-bit signed sum so an upward move past the top goes negative.
        y_sum = $signed({2'b00, y}) + $signed({{5{vy_p[5]}}, vy_p});
        if (y_sum < 0)
            py = '0;
        else if (y_sum > PY_MAX)
            py = PY_MAX[8:0];
        else
            py = y_sum[8:0];
    end
endmodule

// File: rtl/player_physics_sched.sv
// Per-frame physics scheduler for the red (0) and blue (1) players.
// On frame_tick: for red then blue, propose a move, query the shared
// collision checker, commit the result. Owns position, vy and grounded.
//   clk, rst_n          : clock, async active-low reset
//   frame_tick, respawn : frame pulse, spawn reload pulse
//   wsad_red/wsad_blue  : held key levels ([0]jump [1]left [3]right)
//   col                 : collision query channel (master)
//   x_/y_red, x_/y_blue : committed positions
//   busy, frame_done    : sequencing in progress, frame complete pulse
//   err_overrun, err_tmo: sticky tick-while-busy and ack timeout flags
//   dbg_state           : current FSM state
module player_physics_sched
    import game_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  respawn,
    input  logic [3:0]            wsad_red,
    input  logic [3:0]            wsad_blue,
    player_physics_sched_if.master col,
    output logic [9:0]            x_red,
    output logic [8:0]            y_red,
    output logic [9:0]            x_blue,
    output logic [8:0]            y_blue,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_overrun,
    output logic                  err_tmo,
    output sched_state_t          dbg_state
);
    localparam logic signed [6:0] VY_CEIL = 7'(MAX_FALL);

    sched_state_t      state_q, state_d;
    logic              player_q;
    logic [3:0]        keys_q [2];
    logic [9:0]        x_q    [2];
    logic [8:0]        y_q    [2];
    logic signed [5:0] vy_q   [2];
    logic              gnd_q  [2];
    logic [9:0]        px_q, k_px;
    logic [8:0]        py_q, k_py;
    logic signed [5:0] vyp_q, k_vyp;
    logic [1:0]        hit_q;
    logic [7:0]        tmo_cnt;
    logic              tmo_hit;
    logic              pend_rsp;
    logic              spawn_now;
    logic signed [6:0] vy_inc;
    logic [3:0]        k_keys;
    logic              unused_down;

    assign k_keys      = keys_q[player_q];
    assign unused_down = k_keys[KEY_DOWN];

    player_kinematics u_kin (
        .key_jump  (k_keys[KEY_JUMP]),
        .key_left  (k_keys[KEY_LEFT]),
        .key_right (k_keys[KEY_RIGHT]),
        .x         (x_q[player_q]),
        .y         (y_q[player_q]),
        .vy        (vy_q[player_q]),
        .grounded  (gnd_q[player_q]),
        .px        (k_px),
        .py        (k_py),
        .vy_p      (k_vyp)
    );

    assign tmo_hit = (tmo_cnt == 8'(ACK_TMO - 1));
    assign vy_inc  = $signed({vyp_q[5], vyp_q}) + 7'(GRAV);

    // Respawn lands immediately when idle; during a frame it waits for DONE
    // so committed outputs never jump mid-frame.
    assign spawn_now = (state_q == ST_IDLE && respawn) ||
                       (state_q == ST_DONE && (pend_rsp || respawn));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_tick) state_d = ST_PROP;
            ST_PROP:   state_d = ST_QUERY;
            ST_QUERY:  if (col.col_ack || tmo_hit) state_d = ST_COMMIT;
            ST_COMMIT: state_d = player_q ? ST_DONE : ST_PROP;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign col.col_req = (state_q == ST_QUERY);
    assign col.col_id  = player_q;
    assign col.col_x   = px_q;
    assign col.col_y   = py_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;
    assign x_red       = x_q[0];
    assign y_red       = y_q[0];
    assign x_blue      = x_q[1];
    assign y_blue      = y_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_q    <= 1'b0;
            keys_q[0]   <= '0;
            keys_q[1]   <= '0;
            x_q[0]      <= 10'(RED_X0);
            y_q[0]      <= 9'(RED_Y0);
            x_q[1]      <= 10'(BLUE_X0);
            y_q[1]      <= 9'(BLUE_Y0);
            vy_q[0]     <= '0;
            vy_q[1]     <= '0;
            gnd_q[0]    <= 1'b0;
            gnd_q[1]    <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            vyp_q       <= '0;
            hit_q       <= '0;
            tmo_cnt     <= '0;
            pend_rsp    <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            err_tmo     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            tmo_cnt    <= '0;
            if (state_q != ST_IDLE && frame_tick) err_overrun <= 1'b1;
            if (state_q != ST_IDLE && state_q != ST_DONE && respawn) pend_rsp <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (frame_tick) begin
                        keys_q[0] <= wsad_red;
                        keys_q[1] <= wsad_blue;
                        player_q  <= 1'b0;
                    end
                end
                ST_PROP: begin
                    px_q  <= k_px;
                    py_q  <= k_py;
                    vyp_q <= k_vyp;
                end
                ST_QUERY: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (col.col_ack) begin
                        hit_q <= col.col_hit;
                    end else if (tmo_hit) begin
                        // No answer: assume fully blocked so nothing moves.
                        hit_q   <= 2'b11;
                        err_tmo <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (!hit_q[HIT_H]) x_q[player_q] <= px_q;
                    if (!hit_q[HIT_V]) begin
                        y_q[player_q]   <= py_q;
                        gnd_q[player_q] <= 1'b0;
                        vy_q[player_q]  <= (vy_inc > VY_CEIL) ? VY_CEIL[5:0] : vy_inc[5:0];
                    end else begin
                        vy_q[player_q]  <= '0;
                        // Blocked while rising means a ceiling, not a floor.
                        gnd_q[player_q] <= ~vyp_q[5];
                    end
                    player_q <= 1'b1;
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    pend_rsp   <= 1'b0;
                end
                default: ;
            endcase

            // Respawn restores the full spawn state, overriding any commit.
            if (spawn_now) begin
                x_q[0]   <= 10'(RED_X0);
                y_q[0]   <= 9'(RED_Y0);
                x_q[1]   <= 10'(BLUE_X0);
                y_q[1]   <= 9'(BLUE_Y0);
                vy_q[0]  <= '0;
                vy_q[1]  <= '0;
                gnd_q[0] <= 1'b0;
                gnd_q[1] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_player_physics_sched.sv
// Directed bench for player_physics_sched with a reference model and
// scoreboard queues for collision queries and end-of-frame positions.
module tb_player_physics_sched;
    import game_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic         respawn = 1'b0;
    logic [3:0]   wsad_red = '0;
    logic [3:0]   wsad_blue = '0;
    logic [9:0]   x_red, x_blue;
    logic [8:0]   y_red, y_blue;
    logic         busy, frame_done, err_overrun, err_tmo;
    sched_state_t dbg_state;

    player_physics_sched_if col_bus ();

    player_physics_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .respawn     (respawn),
        .wsad_red    (wsad_red),
        .wsad_blue   (wsad_blue),
        .col         (col_bus.master),
        .x_red       (x_red),
        .y_red       (y_red),
        .x_blue      (x_blue),
        .y_blue      (y_blue),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_overrun (err_overrun),
        .err_tmo     (err_tmo),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [19:0] exp_q [$];   // {id, x, y} per collision query
    logic [37:0] pos_q [$];   // {x_red, y_red, x_blue, y_blue} per frame

    int mx [2];
    int my [2];
    int mvy [2];
    bit mg [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_spawn();
        mx[0] = 32;  my[0] = 416;
        mx[1] = 96;  my[1] = 416;
        mvy[0] = 0;  mvy[1] = 0;
        mg[0] = 0;   mg[1] = 0;
    endtask

    task automatic model_prop(input int p, input logic [3:0] k,
                              output int px, output int py, output int vyp);
        px = mx[p];
        if (k[1] && !k[3])      px = (mx[p] - 2 < 0) ? 0 : mx[p] - 2;
        else if (k[3] && !k[1]) px = (mx[p] + 2 > 608) ? 608 : mx[p] + 2;
        vyp = (k[0] && mg[p]) ? -14 : mvy[p];
        py = my[p] + vyp;
        if (py < 0)   py = 0;
        if (py > 448) py = 448;
    endtask

    task automatic model_commit(input int p, input int px, input int py,
                                input int vyp, input logic [1:0] h);
        if (!h[1]) mx[p] = px;
        if (!h[0]) begin
            my[p]  = py;
            mg[p]  = 0;
            mvy[p] = (vyp + 1 > 14) ? 14 : vyp + 1;
        end else begin
            mvy[p] = 0;
            mg[p]  = (vyp >= 0);
        end
    endtask

    // One full frame. w >= 255 means the checker never answers.
    // ovr / rsp_busy pulse during the red query wait (needs wr >= 1).
    task automatic run_frame(input logic [3:0] kr, input logic [3:0] kb,
                             input logic [1:0] hr, input logic [1:0] hb,
                             input int wr, input int wb,
                             input bit rsp_idle, input bit rsp_busy, input bit ovr);
        int px, py, vyp, cyc, n, extra, hold;
        logic [3:0]  k [2];
        logic [1:0]  h [2];
        int          w [2];
        logic [19:0] e;
        logic [37:0] ep;
        k[0] = kr; k[1] = kb; h[0] = hr; h[1] = hb; w[0] = wr; w[1] = wb;

        if (rsp_idle) model_spawn();
        extra = 0;
        for (int p = 0; p < 2; p++) begin
            model_prop(p, k[p], px, py, vyp);
            exp_q.push_back({1'(p), 10'(px), 9'(py)});
            model_commit(p, px, py, vyp, (w[p] >= 255) ? 2'b11 : h[p]);
            extra += (w[p] >= 255) ? 254 : w[p];
        end
        if (rsp_busy) model_spawn();
        pos_q.push_back({10'(mx[0]), 9'(my[0]), 10'(mx[1]), 9'(my[1])});

        @(negedge clk);
        frame_tick = 1'b1; respawn = rsp_idle; wsad_red = kr; wsad_blue = kb;
        @(negedge clk);
        frame_tick = 1'b0; respawn = 1'b0;
        cyc = 1;

        for (int p = 0; p < 2; p++) begin
            n = 0;
            while (!col_bus.col_req && n < 20) begin
                @(negedge clk); cyc++; n++;
            end
            check("col_req_rise", col_bus.col_req, 1'b1);
            e = exp_q.pop_front();
            check("col_query", {col_bus.col_id, col_bus.col_x, col_bus.col_y}, e);
            hold = (w[p] >= 255) ? 254 : w[p];
            for (int i = 0; i < hold; i++) begin
                if (p == 0 && i == 0) begin
                    frame_tick = ovr; respawn = rsp_busy;
                end
                @(negedge clk); cyc++;
                frame_tick = 1'b0; respawn = 1'b0;
                check("col_hold", {col_bus.col_req, col_bus.col_id, col_bus.col_x, col_bus.col_y},
                      {1'b1, e});
            end
            if (w[p] < 255) begin
                col_bus.col_ack = 1'b1;
                col_bus.col_hit = h[p];
            end
            @(negedge clk); cyc++;
            col_bus.col_ack = 1'b0;
            col_bus.col_hit = 2'(($urandom_range(0, 3)));
            check("col_req_drop", col_bus.col_req, 1'b0);
        end

        n = 0;
        while (!frame_done && n < 400) begin
            @(negedge clk); cyc++; n++;
        end
        check("frame_done", frame_done, 1'b1);
        check("latency", cyc - 1, 7 + extra);
        ep = pos_q.pop_front();
        check("positions", {x_red, y_red, x_blue, y_blue}, ep);
        check("busy_idle", busy, 1'b0);
        @(negedge clk);
        check("frame_done_pulse", frame_done, 1'b0);
        check("positions_hold", {x_red, y_red, x_blue, y_blue}, ep);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        col_bus.col_ack = 1'b0;
        col_bus.col_hit = 2'b00;
        model_spawn();

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pos", {x_red, y_red, x_blue, y_blue}, {10'd32, 9'd416, 10'd96, 9'd416});
        check("rst_req", col_bus.col_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_errs", {err_overrun, err_tmo}, 2'b00);
        check("rst_state", dbg_state, ST_IDLE);

        // Idle move right
        run_frame(4'b1000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        check("move_x_red", x_red, 10'd34);
        check("move_y_red", y_red, 9'd416);
        check("move_blue", {x_blue, y_blue}, {10'd96, 9'd416});

        // Land on the floor, then jump
        run_frame(4'b0000, 4'b0000, 2'b01, 2'b01, 0, 0, 0, 0, 0);
        check("land_y_red", y_red, 9'd416);
        run_frame(4'b0001, 4'b0000, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        check("jump_y_red", y_red, 9'd402);
        run_frame(4'b0000, 4'b0000, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        check("rise_y_red", y_red, 9'd389);

        // Mixed keys, hits and ack delays
        for (int i = 0; i < 8; i++)
            run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);

        // Ack stall of 3 cycles in the red query
        run_frame(4'b1000, 4'b0010, 2'b00, 2'b01, 3, 0, 0, 0, 0);

        // Ack timeout on red
        check("tmo_clear", err_tmo, 1'b0);
        run_frame(4'b1001, 4'b0000, 2'b00, 2'b00, 300, 0, 0, 0, 0);
        check("tmo_set", err_tmo, 1'b1);

        // Tick while busy
        check("ovr_clear", err_overrun, 1'b0);
        run_frame(4'b0010, 4'b1000, 2'b00, 2'b00, 2, 0, 0, 0, 1);
        check("ovr_set", err_overrun, 1'b1);
        check("ovr_idle", busy, 1'b0);

        // Respawn during busy
        run_frame(4'b1000, 4'b1000, 2'b00, 2'b00, 2, 1, 0, 1, 0);
        check("rsp_busy_pos", {x_red, y_red, x_blue, y_blue}, {10'd32, 9'd416, 10'd96, 9'd416});

        // Respawn in idle
        run_frame(4'b1000, 4'b0010, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); respawn = 1'b1;
        @(negedge clk); respawn = 1'b0;
        model_spawn();
        check("rsp_idle_pos", {x_red, y_red, x_blue, y_blue}, {10'd32, 9'd416, 10'd96, 9'd416});
        check("rsp_idle_busy", busy, 1'b0);

        // Respawn and tick together: frame runs from spawn
        run_frame(4'b0010, 4'b0000, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        run_frame(4'b1000, 4'b0000, 2'b01, 2'b01, 0, 0, 1, 0, 0);
        check("rsp_tick_x_red", x_red, 10'd34);

        // Left wall
        for (int i = 0; i < 20; i++)
            run_frame(4'b0010, 4'b0000, 2'b01, 2'b01, 0, 0, 0, 0, 0);
        check("left_wall_x", x_red, 10'd0);

        // Right wall, last frame horizontally blocked
        for (int i = 0; i < 260; i++)
            run_frame(4'b0000, 4'b1000, 2'b01, (i == 259) ? 2'b10 : 2'b01, 0, 0, 0, 0, 0);
        check("right_wall_x", x_blue, 10'd608);

        // Async reset in the middle of a query
        @(negedge clk); frame_tick = 1'b1; wsad_red = 4'b1000;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        check("pre_rst_req", col_bus.col_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", col_bus.col_req, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        model_spawn();
        @(negedge clk);
        check("post_rst_pos", {x_red, y_red, x_blue, y_blue}, {10'd32, 9'd416, 10'd96, 9'd416});
        check("post_rst_errs", {err_overrun, err_tmo, frame_done, busy}, 4'b0000);
        check("post_rst_state", dbg_state, ST_IDLE);

        // Normal frame after reset
        run_frame(4'b1000, 4'b0000, 2'b00, 2'b00, 1, 1, 0, 0, 0);
        check("post_rst_move", x_red, 10'd34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
